// File: rtl/mips_register_file.sv
// mips_register_file: 32x32 MIPS register file with a valid/ready serial dump port; define REGFILE_BYPASS_EN for WB->ID write-before-read bypass.
module mips_register_file #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_reg_write,
    input  logic [ADDR_WIDTH-1:0] i_write_register,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [ADDR_WIDTH-1:0] i_read_register_1,
    input  logic [ADDR_WIDTH-1:0] i_read_register_2,
    output logic [DATA_WIDTH-1:0] o_read_data_1,
    output logic [DATA_WIDTH-1:0] o_read_data_2,
    input  logic                  i_dump_start,
    output logic                  o_dump_valid,
    input  logic                  i_dump_ready,
    output logic [ADDR_WIDTH-1:0] o_dump_index,
    output logic [DATA_WIDTH-1:0] o_dump_data,
    output logic                  o_dump_busy,
    output logic                  o_dump_done
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [ADDR_WIDTH-1:0] idx_q, idx_d, idx_nxt;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_en;

    assign wr_en   = i_reg_write && i_write_register != '0 && int'(i_write_register) < NUM_REGS;
    assign idx_nxt = idx_q + 1'b1;

    function automatic logic [DATA_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] a);
        if (a == '0 || int'(a) >= NUM_REGS) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && a == i_write_register) return i_write_data;
`endif
        return regs_q[a];
    endfunction

    always_comb begin
        o_read_data_1 = rd(i_read_register_1);
        o_read_data_2 = rd(i_read_register_2);
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[i_write_register] = i_write_data;
    end

    // Each accepted word loads the next index and its value on the same edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (i_dump_start) begin
                state_d = SEND;
                idx_d   = '0;
                data_d  = '0;
            end
            SEND: if (i_dump_ready) begin
                if (int'(idx_q) == NUM_REGS - 1) state_d = DONE;
                else begin
                    idx_d  = idx_nxt;
                    data_d = rd(idx_nxt);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q  <= '{default: '0};
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign o_dump_valid = state_q == SEND;
    assign o_dump_busy  = state_q != IDLE;
    assign o_dump_done  = state_q == DONE;
    assign o_dump_index = idx_q;
    assign o_dump_data  = data_q;
endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: directed bench for mips_register_file with a dump-word scoreboard.
module tb_mips_register_file;
    localparam int N = 32;
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_reg_write = 1'b0;
    logic [4:0]  i_write_register = '0;
    logic [31:0] i_write_data = '0;
    logic [4:0]  i_read_register_1 = '0;
    logic [4:0]  i_read_register_2 = '0;
    logic [31:0] o_read_data_1, o_read_data_2;
    logic        i_dump_start = 1'b0;
    logic        o_dump_valid;
    logic        i_dump_ready = 1'b0;
    logic [4:0]  o_dump_index;
    logic [31:0] o_dump_data;
    logic        o_dump_busy, o_dump_done;

    word_t       exp_q[$];
    logic [31:0] mdl [N];
    int          checks = 0;
    int          failures = 0;

    mips_register_file dut (
        .clk(clk), .reset(reset),
        .i_reg_write(i_reg_write), .i_write_register(i_write_register), .i_write_data(i_write_data),
        .i_read_register_1(i_read_register_1), .i_read_register_2(i_read_register_2),
        .o_read_data_1(o_read_data_1), .o_read_data_2(o_read_data_2),
        .i_dump_start(i_dump_start), .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
        .o_dump_index(o_dump_index), .o_dump_data(o_dump_data),
        .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        i_reg_write = 1'b1;
        i_write_register = a;
        i_write_data = d;
        step();
        i_reg_write = 1'b0;
        if (a != 0) mdl[a] = d;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(o_dump_valid), 64'(0));
        chk({tag, "_busy"}, 64'(o_dump_busy), 64'(0));
        chk({tag, "_done"}, 64'(o_dump_done), 64'(0));
        chk({tag, "_index"}, 64'(o_dump_index), 64'(0));
        chk({tag, "_data"}, 64'(o_dump_data), 64'(0));
    endtask

    // toggle: ready follows 1,0,0,1, a start pulse lands mid-dump and WB writes hit r20 and r1.
    task automatic run_dump(input bit toggle, input string tag);
        logic [4:0]  pidx = '0;
        logic [31:0] pdata = '0;
        bit          stalled = 0;
        bit          done_seen = 0;
        bit          rdy;
        word_t       w;
        int          n = 0;
        for (int k = 0; k < N; k++) exp_q.push_back({5'(k), mdl[k]});
        i_dump_start = 1'b1;
        i_dump_ready = 1'b1;
        while (n < 200 && !done_seen) begin
            step();
            n++;
            i_reg_write = 1'b0;
            i_dump_start = toggle && n == 5;
            if (n == 1) chk({tag, "_first_valid"}, 64'(o_dump_valid), 64'(1));
            if (o_dump_done) begin
                done_seen = 1;
                if (!toggle) chk({tag, "_done_cycle"}, 64'(n + 1), 64'(N + 2));
                chk({tag, "_words_left"}, 64'(exp_q.size()), 64'(0));
            end else begin
                rdy = toggle ? (n % 4 == 1 || n % 4 == 0) : 1'b1;
                i_dump_ready = rdy;
                if (o_dump_valid) begin
                    if (stalled) begin
                        chk({tag, "_stall_index"}, 64'(o_dump_index), 64'(pidx));
                        chk({tag, "_stall_data"}, 64'(o_dump_data), 64'(pdata));
                    end
                    if (rdy && exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        chk({tag, "_index"}, 64'(o_dump_index), 64'(w.idx));
                        chk({tag, "_data"}, 64'(o_dump_data), 64'(w.data));
                    end
                    stalled = !rdy;
                    pidx = o_dump_index;
                    pdata = o_dump_data;
                end
                if (toggle && n == 8) begin
                    i_reg_write = 1'b1;
                    i_write_register = 5'd20;
                    i_write_data = 32'hCAFEF00D;
                    mdl[20] = 32'hCAFEF00D;
                    foreach (exp_q[j]) if (exp_q[j].idx == 5'd20) exp_q[j].data = 32'hCAFEF00D;
                end
                if (toggle && n == 9) begin
                    i_reg_write = 1'b1;
                    i_write_register = 5'd1;
                    i_write_data = 32'h00000BAD;
                    mdl[1] = 32'h00000BAD;
                end
            end
        end
        i_reg_write = 1'b0;
        i_dump_start = 1'b0;
        chk({tag, "_done_seen"}, 64'(done_seen), 64'(1));
        exp_q.delete();
        step();
        chk({tag, "_done_pulse_end"}, 64'(o_dump_done), 64'(0));
        chk({tag, "_busy_end"}, 64'(o_dump_busy), 64'(0));
    endtask

    initial begin
        int n;
        foreach (mdl[k]) mdl[k] = '0;
        #2 reset = 1'b0;
        #1 chk_idle("reset_async");
        step();
        step();
        reset = 1'b1;
        chk_idle("reset_hold");

        for (int k = 0; k < N; k++) begin
            i_read_register_1 = 5'(k);
            i_read_register_2 = 5'(N - 1 - k);
            #1;
            chk("t1_rd1_zero", 64'(o_read_data_1), 64'(0));
            chk("t1_rd2_zero", 64'(o_read_data_2), 64'(0));
        end
        wr(5'd0, 32'hDEADBEEF);
        i_read_register_1 = 5'd0;
        #1 chk("t1_r0_write_dropped", 64'(o_read_data_1), 64'(0));

        wr(5'd5, 32'h12345678);
        i_read_register_1 = 5'd5;
        i_read_register_2 = 5'd5;
        #1;
        chk("t2_rd1_r5", 64'(o_read_data_1), 64'(32'h12345678));
        chk("t2_rd2_r5", 64'(o_read_data_2), 64'(32'h12345678));

        i_read_register_1 = 5'd7;
        i_reg_write = 1'b1;
        i_write_register = 5'd7;
        i_write_data = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("t3_same_cycle_r7", 64'(o_read_data_1), 64'(32'hA5A5A5A5));
`else
        chk("t3_same_cycle_r7", 64'(o_read_data_1), 64'(mdl[7]));
`endif
        step();
        i_reg_write = 1'b0;
        mdl[7] = 32'hA5A5A5A5;
        chk("t3_after_write_r7", 64'(o_read_data_1), 64'(32'hA5A5A5A5));

        for (int k = 1; k < N; k++) wr(5'(k), 32'(k * 32'h11));
        run_dump(1'b0, "t4");

        run_dump(1'b1, "t5");
        i_read_register_1 = 5'd1;
        i_read_register_2 = 5'd20;
        #1;
        chk("t5_r1_after", 64'(o_read_data_1), 64'(32'h00000BAD));
        chk("t5_r20_after", 64'(o_read_data_2), 64'(32'hCAFEF00D));

        i_dump_start = 1'b1;
        i_dump_ready = 1'b1;
        step();
        i_dump_start = 1'b0;
        n = 0;
        while (o_dump_index != 5'd10 && n < 50) begin
            step();
            n++;
        end
        chk("t6_reach_index10", 64'(o_dump_index), 64'(10));
        chk("t6_valid_at10", 64'(o_dump_valid), 64'(1));
        #2 reset = 1'b0;
        #1 chk_idle("t6_abort");
        step();
        chk_idle("t6_abort_hold");
        reset = 1'b1;
        foreach (mdl[k]) mdl[k] = '0;
        step();
        chk_idle("t6_after_release");
        run_dump(1'b0, "t6_redump");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
